mdio_master: RTL and testbench

Clause 22 MDIO management master for the switch's MAC controllers. It accepts one PHY register read or write per request, generates MDC with an internal clock-enable divider, and serialises the management frame on a tri-state MDIO pin. It sits downstream of the per-port reset synchronizer, whose `rst_n_out` drives `rst_n_in` here, and it replaces a derived-clock MDC: all logic runs on `clk`.

---
 rtl/mac_mgmt_pkg.sv | 22 ++
 rtl/mdc_tick_gen.sv | 42 ++++
 rtl/mdio_master.sv | 139 +++++++++++++
 tb/tb_mdio_master.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_mgmt_pkg.sv
// Shared types and frame constants for the Clause 22 MDIO management master.
package mac_mgmt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } mdio_state_t;

    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam int         MDIO_HDR_BITS = 32;

    // On a read the PHY owns the line from the turnaround onwards.
    function automatic logic mdio_bit_driven(input logic       is_read,
                                             input logic [6:0] idx,
                                             input logic [6:0] ta_idx);
        return !(is_read && (idx >= ta_idx));
    endfunction

endpackage

// File: rtl/mdc_tick_gen.sv
// MDC clock-enable divider: counts MDC_DIV clk cycles per half-period and
// flags the edges where MDC is about to rise or fall.
module mdc_tick_gen #(
    parameter int MDC_DIV = 10
) (
    input  logic clk,
    input  logic rst_n_in,
    input  logic run,
    output logic fall_tick,
    output logic rise_tick,
    output logic mdc
);

    localparam int                CNT_W   = $clog2(MDC_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MDC_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             mdc_q;
    logic             half_end;

    assign half_end  = run && (cnt_q == CNT_MAX);
    assign rise_tick = half_end && !mdc_q;
    assign fall_tick = half_end && mdc_q;
    assign mdc       = mdc_q;

    // Dropping run parks the phase low so a frame never starts mid-pulse.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else if (half_end) begin
            cnt_q <= '0;
            mdc_q <= ~mdc_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one register read or write per request, serialised
// MSB first on a tri-state MDIO pin with MDC derived from a clock enable.
module mdio_master
    import mac_mgmt_pkg::*;
#(
    parameter int MDC_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int         FRAME_BITS = PREAMBLE_LEN + MDIO_HDR_BITS;
    localparam logic [6:0] LAST_IDX   = 7'(FRAME_BITS - 1);
    localparam logic [6:0] TA_IDX     = 7'(PREAMBLE_LEN + 14);
    localparam logic [6:0] DATA_IDX   = 7'(PREAMBLE_LEN + 16);

    mdio_state_t           state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] frame_d;
    logic [6:0]            bit_cnt_q;
    logic                  is_read_q;
    logic                  run_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [15:0]           rdata_q;
    logic                  mdio_o_q;
    logic                  mdio_oe_q;
    logic                  fall_tick;
    logic                  rise_tick;

    mdc_tick_gen #(
        .MDC_DIV(MDC_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n_in (rst_n_in),
        .run      (run_q),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick),
        .mdc      (mdc)
    );

    // Preamble bits stay at the all-ones default; read TA/data slots are
    // placeholders since the line is released there.
    always_comb begin
        frame_d = '1;
        frame_d[MDIO_HDR_BITS-1:0] = {MDIO_ST,
                                      req_write ? MDIO_OP_WRITE : MDIO_OP_READ,
                                      req_phy_addr,
                                      req_reg_addr,
                                      req_write ? 2'b10 : 2'b11,
                                      req_write ? req_wdata : 16'hFFFF};
    end

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            run_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        shift_q     <= frame_d;
                        is_read_q   <= !req_write;
                        bit_cnt_q   <= '0;
                        rdata_q     <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!run_q) begin
                        // First SHIFT cycle: present bit 0 and start the divider.
                        run_q     <= 1'b1;
                        mdio_o_q  <= shift_q[FRAME_BITS-1];
                        mdio_oe_q <= mdio_bit_driven(is_read_q, 7'd0, TA_IDX);
                        shift_q   <= shift_q << 1;
                    end else begin
                        if (rise_tick && is_read_q && (bit_cnt_q >= DATA_IDX)) begin
                            rdata_q <= {rdata_q[14:0], mdio_i};
                        end
                        if (fall_tick) begin
                            if (bit_cnt_q == LAST_IDX) begin
                                run_q       <= 1'b0;
                                mdio_o_q    <= 1'b1;
                                mdio_oe_q   <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 7'd1;
                                mdio_o_q  <= shift_q[FRAME_BITS-1];
                                mdio_oe_q <= mdio_bit_driven(is_read_q, bit_cnt_q + 7'd1, TA_IDX);
                                shift_q   <= shift_q << 1;
                            end
                        end
                    end
                end

                DONE: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: frame bit patterns, read capture, latency,
// back-to-back handshakes, mid-frame reset and the no-preamble configuration.
module tb_mdio_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;

    logic        req_write = 1'b0;
    logic [4:0]  req_phy = 5'h0;
    logic [4:0]  req_reg = 5'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        mdio_i = 1'b1;
    logic        req_valid0 = 1'b0;
    logic        req_valid1 = 1'b0;

    logic        req_ready0, rsp_valid0, mdc0, mdio_o0, mdio_oe0;
    logic        req_ready1, rsp_valid1, mdc1, mdio_o1, mdio_oe1;
    logic [15:0] rsp_rdata0, rsp_rdata1;

    logic        sel = 1'b0;
    logic        s_ready, s_rsp, s_mdc, s_o, s_oe;
    logic [15:0] s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdio_master #(.MDC_DIV(4), .PREAMBLE_LEN(32)) dut (
        .clk(clk), .rst_n_in(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
        .req_phy_addr(req_phy), .req_reg_addr(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .mdc(mdc0), .mdio_o(mdio_o0), .mdio_oe(mdio_oe0), .mdio_i(mdio_i)
    );

    mdio_master #(.MDC_DIV(2), .PREAMBLE_LEN(0)) dut_p0 (
        .clk(clk), .rst_n_in(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write),
        .req_phy_addr(req_phy), .req_reg_addr(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .mdc(mdc1), .mdio_o(mdio_o1), .mdio_oe(mdio_oe1), .mdio_i(mdio_i)
    );

    assign s_ready = sel ? req_ready1 : req_ready0;
    assign s_rsp   = sel ? rsp_valid1 : rsp_valid0;
    assign s_mdc   = sel ? mdc1       : mdc0;
    assign s_o     = sel ? mdio_o1    : mdio_o0;
    assign s_oe    = sel ? mdio_oe1   : mdio_oe0;
    assign s_rdata = sel ? rsp_rdata1 : rsp_rdata0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) req_valid1 = v;
        else     req_valid0 = v;
    endtask

    // Issues one request and follows the frame, capturing mdio_o/mdio_oe at
    // each MDC rise and acting as the PHY on the data bits of a read.
    task automatic run_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] wd, input logic [15:0] phy_data,
                             input int nbits, input bit hold, input int abort_bit,
                             output logic [63:0] bits, output logic [63:0] oes,
                             output logic [15:0] rdata, output int hs_cyc, output int rsp_cyc);
        int  k;
        int  nrsp;
        logic prev_mdc;
        bit  done;
        bits = '0; oes = '0; rdata = '0; hs_cyc = -1; rsp_cyc = -1;
        @(negedge clk);
        req_write = wr; req_phy = phy; req_reg = rg; req_wdata = wd;
        set_valid(1'b1);
        for (int t = 0; t < 50 && !s_ready; t++) @(negedge clk);
        if (!s_ready) begin
            check_eq("handshake_timeout", 64'd0, 64'd1);
            set_valid(1'b0);
            return;
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (!hold) set_valid(1'b0);
        k = 0; prev_mdc = 1'b0; done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (s_mdc && !prev_mdc) begin
                if (k < nbits) begin
                    bits[nbits-1-k] = s_o;
                    oes[nbits-1-k]  = s_oe;
                end
                k++;
                if (hold && k == 20) begin
                    req_write = 1'b1; req_phy = 5'h15; req_reg = 5'h0A; req_wdata = 16'h0F0F;
                end
                if (k == abort_bit) begin
                    #2 rst_n = 1'b0;
                    #1 check_eq("abort_outs",
                                64'({s_ready, s_rsp, s_mdc, s_o, s_oe}), 64'b10010);
                    @(negedge clk);
                    rst_n = 1'b1;
                    nrsp = 0;
                    for (int w = 0; w < 30; w++) begin
                        @(negedge clk);
                        if (s_rsp) nrsp++;
                    end
                    check_eq("abort_no_rsp", 64'(nrsp), 64'd0);
                    check_eq("abort_ready", 64'({s_ready, s_oe, s_mdc}), 64'b100);
                    done = 1'b1;
                end
            end
            if (!s_mdc && prev_mdc) begin
                if (k >= nbits - 16 && k < nbits) mdio_i = phy_data[15-(k-(nbits-16))];
                else                              mdio_i = 1'b1;
            end
            prev_mdc = s_mdc;
            if (!done && s_rsp) begin
                rsp_cyc = cyc;
                rdata   = s_rdata;
                check_eq("done_outs", 64'({s_mdc, s_oe, s_ready}), 64'd0);
                done = 1'b1;
            end
        end
        if (!done) check_eq("rsp_timeout", 64'd0, 64'd1);
    endtask

    logic [63:0] bits, oes;
    logic [15:0] rdata;
    int          hs, rsp, hs_a, rsp_a;

    initial begin
        // Reset asserted mid-cycle takes effect immediately.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_outs0", 64'({req_ready0, rsp_valid0, mdc0, mdio_o0, mdio_oe0, rsp_rdata0}),
                    64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}));
        check_eq("reset_outs1", 64'({req_ready1, rsp_valid1, mdc1, mdio_o1, mdio_oe1, rsp_rdata1}),
                 64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", 64'(req_ready0), 64'd1);

        // Write, MDC_DIV=4, 32-bit preamble.
        run_frame(1'b1, 5'h01, 5'h00, 16'hA5C3, 16'h0000, 64, 1'b0, -1, bits, oes, rdata, hs, rsp);
        check_eq("wr_bits", bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'hA5C3});
        check_eq("wr_oe", oes, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("wr_latency", 64'(rsp - hs), 64'd513);
        check_eq("wr_rdata", 64'(rdata), 64'h0);

        // Read: PHY returns 16'h0141, line released for TA and data.
        run_frame(1'b0, 5'h1F, 5'h02, 16'hFFFF, 16'h0141, 64, 1'b0, -1, bits, oes, rdata, hs, rsp);
        check_eq("rd_bits", bits & 64'hFFFF_FFFF_FFFC_0000,
                 {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h02, 18'h0});
        check_eq("rd_oe", oes, 64'hFFFF_FFFF_FFFC_0000);
        check_eq("rd_latency", 64'(rsp - hs), 64'd513);
        check_eq("rd_rdata", 64'(rdata), 64'h0141);
        repeat (2) @(negedge clk);
        check_eq("rd_rdata_hold", 64'(rsp_rdata0), 64'h0141);

        // Idle reset clears the held read data.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_rdata", 64'(rsp_rdata0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: valid held, fields swapped to B mid-frame.
        run_frame(1'b1, 5'h03, 5'h11, 16'h1234, 16'h0000, 64, 1'b1, -1, bits, oes, rdata, hs_a, rsp_a);
        check_eq("btb_a_bits", bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03, 5'h11, 2'b10, 16'h1234});
        run_frame(1'b1, 5'h15, 5'h0A, 16'h0F0F, 16'h0000, 64, 1'b0, -1, bits, oes, rdata, hs, rsp);
        check_eq("btb_gap", 64'(hs - rsp_a), 64'd2);
        check_eq("btb_b_bits", bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h15, 5'h0A, 2'b10, 16'h0F0F});

        // Reset during bit 40 aborts the frame, then a clean write follows.
        run_frame(1'b1, 5'h07, 5'h04, 16'hBEEF, 16'h0000, 64, 1'b0, 41, bits, oes, rdata, hs, rsp);
        run_frame(1'b1, 5'h02, 5'h1C, 16'h5A5A, 16'h0000, 64, 1'b0, -1, bits, oes, rdata, hs, rsp);
        check_eq("post_abort_bits", bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h02, 5'h1C, 2'b10, 16'h5A5A});
        check_eq("post_abort_latency", 64'(rsp - hs), 64'd513);

        // No preamble, MDC_DIV=2.
        sel = 1'b1;
        run_frame(1'b1, 5'h09, 5'h03, 16'hC0DE, 16'h0000, 32, 1'b0, -1, bits, oes, rdata, hs, rsp);
        check_eq("p0_bits", bits, 64'({2'b01, 2'b01, 5'h09, 5'h03, 2'b10, 16'hC0DE}));
        check_eq("p0_oe", oes, 64'hFFFF_FFFF);
        check_eq("p0_latency", 64'(rsp - hs), 64'd129);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
